// File: rtl/arm_operand_pkg.sv
// Shared definitions for the ARM data-processing immediate encoder and decoder.
// Holds field widths, the encoder state type and the even-rotation helpers.
package arm_operand_pkg;

    localparam int ROT_STEPS = 16;
    localparam int IMM8_W    = 8;
    localparam int IMM12_W   = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_SEARCH_INV,
        ST_DONE
    } enc_state_e;

    // Rotate left by 2*r: the upper half of the doubled word shifted left is the rotation.
    function automatic logic [31:0] rol2r(input logic [31:0] v, input logic [3:0] r);
        logic [63:0] dbl;
        dbl = {v, v} << {r, 1'b0};
        return dbl[63:32];
    endfunction

    // Decoder counterpart: rotate right by 2*r.
    function automatic logic [31:0] ror2r(input logic [31:0] v, input logic [3:0] r);
        logic [63:0] dbl;
        dbl = {v, v} >> {r, 1'b0};
        return dbl[31:0];
    endfunction

endpackage

// File: rtl/imm_rotate_encoder_if.sv
// Request/response handshake bundle between the assembler front end and the immediate encoder.
interface imm_rotate_encoder_if;
    import arm_operand_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [31:0]          req_value;
    logic                 req_inv_ok;
    logic                 abort;
    logic                 resp_valid;
    logic                 resp_ready;
    logic                 resp_found;
    logic                 resp_inverted;
    logic [IMM12_W-1:0]   resp_imm12;
    logic                 resp_carry;
    logic                 resp_carry_is_cin;

    modport master (
        output req_valid, req_value, req_inv_ok, abort, resp_ready,
        input  req_ready, resp_valid, resp_found, resp_inverted, resp_imm12,
               resp_carry, resp_carry_is_cin
    );

    modport slave (
        input  req_valid, req_value, req_inv_ok, abort, resp_ready,
        output req_ready, resp_valid, resp_found, resp_inverted, resp_imm12,
               resp_carry, resp_carry_is_cin
    );

endinterface

// File: rtl/imm_rotate_encoder_rot_check.sv
// Single-rotation test: does cand rotated left by 2*r fit in the low eight bits?
module imm_rot_check
    import arm_operand_pkg::*;
(
    input  logic [31:0]       cand,
    input  logic [3:0]        r,
    output logic              hit,
    output logic [IMM8_W-1:0] imm8
);

    logic [31:0] rol;

    always_comb begin
        rol  = rol2r(cand, r);
        hit  = (rol[31:IMM8_W] == '0);
        imm8 = rol[IMM8_W-1:0];
    end

endmodule

// File: rtl/imm_rotate_encoder.sv
// Iterative {rot4, imm8} encoder: tries one even rotation per cycle, optionally
// followed by a second pass over the complemented operand.
module imm_rotate_encoder
    import arm_operand_pkg::*;
#(
    parameter bit ENABLE_INVERT = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    imm_rotate_encoder_if.slave      bus
);

    enc_state_e          state_q, state_d;
    logic [31:0]         cand_q, cand_d;
    logic [3:0]          r_q, r_d;
    logic                inv_allowed_q, inv_allowed_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_found_q, resp_found_d;
    logic                resp_inverted_q, resp_inverted_d;
    logic [IMM12_W-1:0]  resp_imm12_q, resp_imm12_d;
    logic                resp_carry_q, resp_carry_d;
    logic                resp_carry_is_cin_q, resp_carry_is_cin_d;

    logic                hit;
    logic [IMM8_W-1:0]   imm8;

    imm_rot_check u_rot_check (
        .cand (cand_q),
        .r    (r_q),
        .hit  (hit),
        .imm8 (imm8)
    );

    always_comb begin
        state_d             = state_q;
        cand_d              = cand_q;
        r_d                 = r_q;
        inv_allowed_d       = inv_allowed_q;
        req_ready_d         = req_ready_q;
        resp_valid_d        = resp_valid_q;
        resp_found_d        = resp_found_q;
        resp_inverted_d     = resp_inverted_q;
        resp_imm12_d        = resp_imm12_q;
        resp_carry_d        = resp_carry_q;
        resp_carry_is_cin_d = resp_carry_is_cin_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    cand_d        = bus.req_value;
                    inv_allowed_d = bus.req_inv_ok && ENABLE_INVERT;
                    r_d           = 4'd0;
                    req_ready_d   = 1'b0;
                    state_d       = ST_SEARCH;
                end
            end

            ST_SEARCH, ST_SEARCH_INV: begin
                if (bus.abort) begin
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (hit) begin
                    resp_valid_d        = 1'b1;
                    resp_found_d        = 1'b1;
                    resp_inverted_d     = (state_q == ST_SEARCH_INV);
                    resp_imm12_d        = {r_q, imm8};
                    // Encoded value's bit 31 is the candidate's bit 31, whichever pass found it.
                    resp_carry_d        = (r_q != 4'd0) && cand_q[31];
                    resp_carry_is_cin_d = (r_q == 4'd0);
                    state_d             = ST_DONE;
                end else if (r_q != 4'(ROT_STEPS - 1)) begin
                    r_d = r_q + 4'd1;
                end else if (state_q == ST_SEARCH && inv_allowed_q) begin
                    cand_d  = ~cand_q;
                    r_d     = 4'd0;
                    state_d = ST_SEARCH_INV;
                end else begin
                    resp_valid_d        = 1'b1;
                    resp_found_d        = 1'b0;
                    resp_inverted_d     = 1'b0;
                    resp_imm12_d        = '0;
                    resp_carry_d        = 1'b0;
                    resp_carry_is_cin_d = 1'b0;
                    state_d             = ST_DONE;
                end
            end

            ST_DONE: begin
                if (bus.abort || bus.resp_ready) begin
                    resp_valid_d        = 1'b0;
                    resp_found_d        = 1'b0;
                    resp_inverted_d     = 1'b0;
                    resp_imm12_d        = '0;
                    resp_carry_d        = 1'b0;
                    resp_carry_is_cin_d = 1'b0;
                    req_ready_d         = 1'b1;
                    state_d             = ST_IDLE;
                end
            end

            default: begin
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q             <= ST_IDLE;
            cand_q              <= '0;
            r_q                 <= '0;
            inv_allowed_q       <= 1'b0;
            req_ready_q         <= 1'b1;
            resp_valid_q        <= 1'b0;
            resp_found_q        <= 1'b0;
            resp_inverted_q     <= 1'b0;
            resp_imm12_q        <= '0;
            resp_carry_q        <= 1'b0;
            resp_carry_is_cin_q <= 1'b0;
        end else begin
            state_q             <= state_d;
            cand_q              <= cand_d;
            r_q                 <= r_d;
            inv_allowed_q       <= inv_allowed_d;
            req_ready_q         <= req_ready_d;
            resp_valid_q        <= resp_valid_d;
            resp_found_q        <= resp_found_d;
            resp_inverted_q     <= resp_inverted_d;
            resp_imm12_q        <= resp_imm12_d;
            resp_carry_q        <= resp_carry_d;
            resp_carry_is_cin_q <= resp_carry_is_cin_d;
        end
    end

    assign bus.req_ready         = req_ready_q;
    assign bus.resp_valid        = resp_valid_q;
    assign bus.resp_found        = resp_found_q;
    assign bus.resp_inverted     = resp_inverted_q;
    assign bus.resp_imm12        = resp_imm12_q;
    assign bus.resp_carry        = resp_carry_q;
    assign bus.resp_carry_is_cin = resp_carry_is_cin_q;

endmodule

// File: tb/tb_imm_rotate_encoder.sv
// Directed bench for imm_rotate_encoder: hand-computed encodings, latencies, abort and reset.
module tb_imm_rotate_encoder;

    logic clk;
    logic reset_n;
    int   tests;
    int   fails;

    imm_rotate_encoder_if enc_if ();

    imm_rotate_encoder #(.ENABLE_INVERT(1'b1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (enc_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input string tag, input logic [31:0] val, input logic inv,
                           input int exp_lat, input logic exp_found, input logic exp_inv,
                           input logic [11:0] exp_imm, input logic exp_carry,
                           input logic exp_cin, input int hold);
        int  n;
        bit  got;
        @(negedge clk);
        check({tag, " req_ready idle"}, 32'(enc_if.req_ready), 32'd1);
        enc_if.req_valid  = 1'b1;
        enc_if.req_value  = val;
        enc_if.req_inv_ok = inv;
        @(posedge clk);
        #1;
        enc_if.req_valid  = 1'b0;
        enc_if.req_value  = 32'hDEADBEEF;
        enc_if.req_inv_ok = ~inv;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (enc_if.resp_valid) got = 1'b1;
        end
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " found"}, 32'(enc_if.resp_found), 32'(exp_found));
        check({tag, " inverted"}, 32'(enc_if.resp_inverted), 32'(exp_inv));
        check({tag, " imm12"}, 32'(enc_if.resp_imm12), 32'(exp_imm));
        if (exp_found) begin
            check({tag, " carry"}, 32'(enc_if.resp_carry), 32'(exp_carry));
            check({tag, " carry_is_cin"}, 32'(enc_if.resp_carry_is_cin), 32'(exp_cin));
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, " hold valid"}, 32'(enc_if.resp_valid), 32'd1);
            check({tag, " hold imm12"}, 32'(enc_if.resp_imm12), 32'(exp_imm));
            check({tag, " hold found"}, 32'(enc_if.resp_found), 32'(exp_found));
            check({tag, " hold req_ready"}, 32'(enc_if.req_ready), 32'd0);
        end
        enc_if.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        enc_if.resp_ready = 1'b0;
        check({tag, " consumed valid"}, 32'(enc_if.resp_valid), 32'd0);
        check({tag, " back req_ready"}, 32'(enc_if.req_ready), 32'd1);
        $display("[TB] %s value=%h inv_ok=%0d latency=%0d imm12=%h", tag, val, inv, n,
                 exp_imm);
    endtask

    initial begin
        int vcnt;
        tests = 0;
        fails = 0;
        reset_n           = 1'b0;
        enc_if.req_valid  = 1'b0;
        enc_if.req_value  = '0;
        enc_if.req_inv_ok = 1'b0;
        enc_if.abort      = 1'b0;
        enc_if.resp_ready = 1'b0;
        #12;
        check("reset req_ready", 32'(enc_if.req_ready), 32'd1);
        check("reset resp_valid", 32'(enc_if.resp_valid), 32'd0);
        check("reset imm12", 32'(enc_if.resp_imm12), 32'd0);
        check("reset found", 32'(enc_if.resp_found), 32'd0);
        check("reset carry_is_cin", 32'(enc_if.resp_carry_is_cin), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_req("ff",          32'h000000FF, 1'b0, 1,  1'b1, 1'b0, 12'h0FF, 1'b0, 1'b1, 0);
        run_req("ff000000",    32'hFF000000, 1'b0, 5,  1'b1, 1'b0, 12'h4FF, 1'b1, 1'b0, 0);
        run_req("f000000f",    32'hF000000F, 1'b0, 3,  1'b1, 1'b0, 12'h2FF, 1'b1, 1'b0, 0);
        run_req("3fc",         32'h000003FC, 1'b0, 16, 1'b1, 1'b0, 12'hFFF, 1'b0, 1'b0, 0);
        run_req("ffffff00 inv",32'hFFFFFF00, 1'b1, 17, 1'b1, 1'b1, 12'h0FF, 1'b0, 1'b1, 0);
        run_req("ffffff00 dir",32'hFFFFFF00, 1'b0, 16, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 0);
        run_req("101 inv",     32'h00000101, 1'b1, 32, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 5);
        run_req("zero",        32'h00000000, 1'b0, 1,  1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 0);

        // Abort during a long miss search.
        @(negedge clk);
        enc_if.req_valid  = 1'b1;
        enc_if.req_value  = 32'h00000101;
        enc_if.req_inv_ok = 1'b1;
        @(posedge clk);
        #1;
        enc_if.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        enc_if.abort = 1'b1;
        @(posedge clk);
        #1;
        enc_if.abort = 1'b0;
        check("abort req_ready", 32'(enc_if.req_ready), 32'd1);
        check("abort resp_valid", 32'(enc_if.resp_valid), 32'd0);
        vcnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (enc_if.resp_valid) vcnt++;
        end
        check("abort no response", 32'(vcnt), 32'd0);
        $display("[TB] abort mid-search valid_cycles=%0d", vcnt);

        // Asynchronous reset during a search.
        @(negedge clk);
        enc_if.req_valid  = 1'b1;
        enc_if.req_value  = 32'h00000101;
        enc_if.req_inv_ok = 1'b1;
        @(posedge clk);
        #1;
        enc_if.req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midreset req_ready", 32'(enc_if.req_ready), 32'd1);
        check("midreset resp_valid", 32'(enc_if.resp_valid), 32'd0);
        check("midreset found", 32'(enc_if.resp_found), 32'd0);
        check("midreset inverted", 32'(enc_if.resp_inverted), 32'd0);
        check("midreset imm12", 32'(enc_if.resp_imm12), 32'd0);
        check("midreset carry", 32'(enc_if.resp_carry), 32'd0);
        check("midreset carry_is_cin", 32'(enc_if.resp_carry_is_cin), 32'd0);
        $display("[TB] reset mid-search req_ready=%0d", enc_if.req_ready);
        @(negedge clk);
        reset_n = 1'b1;

        run_req("ff after reset", 32'h000000FF, 1'b0, 1, 1'b1, 1'b0, 12'h0FF, 1'b0, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imm_rotate_encoder.md
Name: imm_rotate_encoder

Overview:
- Iterative encoder for ARM data-processing immediates: finds the 12-bit {rot4, imm8} field for a 32-bit operand, such that the operand equals imm8 rotated right by 2*rot4.
- Inverse of the operand decoder used by the shift/sign-extend stage.
- Used by the instruction assembler/loader front end. Optionally also searches for an encoding of the bitwise complement, for the MOV to MVN and AND to BIC substitutions.
- Evaluates one rotation per cycle, with valid/ready handshakes on both sides.

Parameters:
- ENABLE_INVERT, 1: 1 enables the complement search pass; 0 removes it (the req_inv_ok input is ignored).

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  encoder idle; a request is accepted on a clk edge where req_valid && req_ready.
- req_value  input  32  operand to encode.
- req_inv_ok  input  1  caller permits a complemented encoding.
- abort  input  1  synchronous cancel of the in-flight search.
- resp_valid  output  1  result available; held until it is consumed.
- resp_ready  input  1  consumer takes the result on a clk edge where resp_valid && resp_ready.
- resp_found  output  1  an encoding exists.
- resp_inverted  output  1  the encoding is of ~req_value.
- resp_imm12  output  12  {rot4, imm8}; 12'h000 when not found.
- resp_carry  output  1  shifter carry the decoder will produce: bit 31 of the encoded value when rot4 != 0; 0 otherwise.
- resp_carry_is_cin  output  1  1 when rot4 == 0, meaning the decoder passes Cin through as the carry.

Behaviour:
- Reset (async, reset_n low): state IDLE.
  - req_ready = 1.
  - resp_valid, resp_found, resp_inverted, resp_carry, resp_carry_is_cin = 0.
  - resp_imm12 = 0.
  - Internal value, step and flag registers cleared.
  - Reset asserted mid-search discards the search. No response is produced.
- States: IDLE, SEARCH, SEARCH_INV, DONE. Internal step counter r is 4 bits.
- IDLE:
  - req_ready = 1.
  - On accept: latch req_value into cand, latch inv_allowed = req_inv_ok && ENABLE_INVERT, set r = 0, go to SEARCH.
- Hit condition, evaluated combinationally each SEARCH / SEARCH_INV cycle:
  - rol = cand rotated left by 2*r.
  - Hit when rol[31:8] == 0.
  - On a hit, register imm8 = rol[7:0], rot4 = r, resp_found = 1, and the carry outputs; go to DONE.
  - The first (smallest) r that hits wins.
- SEARCH, no hit:
  - r < 15: r increments.
  - r == 15 and inv_allowed: cand becomes ~cand, r = 0, go to SEARCH_INV.
  - r == 15 and not inv_allowed: go to DONE with resp_found = 0 and resp_imm12 = 0.
- SEARCH_INV:
  - Same hit rule; a hit also sets resp_inverted = 1.
  - No hit at r == 15: DONE, not found, resp_inverted = 0.
- Latency, counting the accept edge as E0:
  - Direct hit at rotation r: resp_valid is high after edge E0+r+1.
  - Inverted hit at r: high after E0+17+r.
  - Miss: high after E0+16 without the invert pass, E0+32 with it.
- DONE:
  - resp_valid = 1 and all resp_* fields stable.
  - On resp_ready, go to IDLE. req_ready is high the following cycle; no same-cycle re-accept.
- req_ready is 0 in every state except IDLE.
- req_value changes after accept are ignored.
- abort:
  - In SEARCH, SEARCH_INV or DONE, abort goes to IDLE on the next edge with resp_valid = 0 and no response.
  - Abort has priority over a simultaneous hit or resp_ready.
  - Ignored in IDLE, and it does not block a same-cycle accept.
- Value 0 encodes as imm12 0x000 at r = 0 (latency 1), with carry_is_cin = 1.

Decomposition:
- Shared package, arm_operand_pkg:
  - ROT_STEPS = 16.
  - IMM8_W = 8 and IMM12_W = 12.
  - State enum for this FSM.
  - A rotate-left-by-2r function, shared with the decoder's rotate-right.
- One natural sub-module: imm_rot_check, combinational. Takes cand and r; returns hit and imm8. Instantiated once.

Test Plan:
- req_value 0x000000FF, inv_ok 0 -> found = 1, imm12 0x0FF, carry_is_cin = 1, resp_valid after E0+1.
- 0xFF000000 -> imm12 0x4FF, carry = 1, carry_is_cin = 0, resp_valid after E0+5. Also 0xF000000F -> imm12 0x2FF, carry = 1.
- 0x000003FC -> imm12 0xFFF (r = 15), carry = 0, resp_valid after E0+16.
- 0xFFFFFF00 with inv_ok = 1 -> found = 1, inverted = 1, imm12 0x0FF, after E0+17. With inv_ok = 0 -> found = 0, imm12 0x000, after E0+16.
- 0x00000101 with inv_ok = 1 -> found = 0, resp_valid after E0+32. Hold resp_ready = 0 for 5 cycles -> outputs stable and req_ready = 0. Then raise resp_ready -> IDLE, and req_ready = 1 the next cycle.
- Abort at E0+3 during a miss search -> no resp_valid, and IDLE at E0+4. Also assert reset_n low mid-search -> all outputs 0 immediately and req_ready = 1. A following 0x000000FF request then encodes correctly.
